tt_eval_seq: RTL
================

# tt_eval_seq

Parametrised, reprogrammable truth-table evaluator with a settling filter on its output. Generalises the fixed 3-input single-output logic functions to N_IN inputs. The function is held in a 2^N_IN-bit table that can be reloaded at run time over a serial handshake without disturbing evaluation. The output only updates once the input has been stable for HOLD cycles, which models gate settling time. The block sits between the input-sensor stage and the output-reporter stage of the circuit simulation fabric.

## Interface
- N_IN, 3, number of logic inputs (1..6); the table has 2^N_IN rows.
- HOLD, 4, consecutive stable cycles required before the output updates (>=1).
- RESET_TT, 8'hFC, reset truth table (width 2^N_IN); bit i is the output for input row i.

- clk  input  1  single clock; all logic is rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in  input  N_IN  logic inputs; in[N_IN-1] is the row MSB.
- load_start  input  1  one-cycle pulse that begins a table reload.
- cfg_valid  input  1  cfg_bit is valid.
- cfg_ready  output  1  block accepts cfg_bit (high only in LOAD).
- cfg_bit  input  1  serial table bit, sent row 0 first.
- busy  output  1  high while in LOAD.
- out  output  1  registered, filtered function output.
- out_valid  output  1  high when out reflects the current in and the current table.

## Operation
- States:
  - IDLE: evaluate only.
  - LOAD: evaluate with the old table while shifting in the new one.
- IDLE -> LOAD on load_start. The bit counter is cleared and the shadow register is cleared.
- In LOAD, cfg_ready=1. A bit is accepted on an edge with cfg_valid && cfg_ready and is written to shadow[count]; count then increments.
- Commit happens on acceptance of bit 2^N_IN-1:
  - table <= shadow (including the final bit), applied atomically;
  - state returns to IDLE;
  - the settle counter is cleared and out_valid <= 0.
- load_start while in LOAD restarts the load: count=0, and partial shadow contents are discarded. The active table is untouched.
- load_start in the same cycle as the final-bit acceptance: the commit wins; load_start is ignored.
- cfg_valid in IDLE is ignored.
- Evaluation (every cycle, in both states):
  - in_q <= in.
  - If in != in_q: cnt <= 0, out_valid <= 0.
  - Else if cnt < HOLD-1: cnt++.
  - Else (cnt == HOLD-1): out <= table[in_q], out_valid <= 1. cnt saturates.
- out holds its last value while out_valid=0. It never glitches to an intermediate row.
- cnt width is clog2(HOLD)+1. There is no wrap; cnt saturates at HOLD-1.
- Reset (asynchronous, any state, including mid-load):
  - state=IDLE, table=RESET_TT, shadow=0, count=0;
  - in_q=0, cnt=0;
  - out=0, out_valid=0, cfg_ready=0, busy=0.

## Timing
- Input-to-output latency: let e0 be the edge at which in_q first captures a new stable value. out and out_valid update on edge e0+HOLD and are visible in the following cycle.
- Input pulses shorter than HOLD+1 cycles never reach out; only out_valid drops.
- Commit-to-output latency: if in is stable, out reflects the new table on edge commit+HOLD.
- cfg handshake: one bit per cycle at full rate; a full load takes 2^N_IN accepted cycles.
- busy falls on the commit edge.
- An input change and a commit in the same edge both clear cnt; there is no double count.

## Test plan
- Reset, then in=3'b000 held, HOLD=4 -> out=0 and out_valid=1 four edges after capture. Then in=3'b010 held -> out=1 after the same latency; out_valid=0 in between.
- Glitch: in 000 -> 101 for 2 cycles -> 000 -> out stays 0 throughout; out_valid drops, then reasserts.
- Reload 8'h01 (bits 1,0,0,0,0,0,0,0), with in=3'b111 held during the load -> out stays 1 through the load. After the commit edge, out=0 four edges later. busy is high for exactly 8 accepting cycles.
- Throttled load: cfg_valid toggles every other cycle -> only valid cycles are counted; commit after the 8th accepted bit.
- load_start after 5 bits, then 8 fresh bits 8'hAA -> the table equals 8'hAA, not a mix. in=3'b001 -> out=1; in=3'b000 -> out=0.
- Assert rst mid-load after 3 bits -> table=8'hFC, busy=0, out=0, out_valid=0 immediately. in=3'b001 held -> out=0; in=3'b100 -> out=1.

Source files
------------

// File: rtl/tt_eval_seq.sv
// tt_eval_seq: reloadable N_IN-input truth-table evaluator.
// Output only updates after the input has been stable for HOLD cycles.
module tt_eval_seq #(
  parameter int                     N_IN     = 3,
  parameter int                     HOLD     = 4,
  parameter logic [(1<<N_IN)-1:0]   RESET_TT = 8'hFC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] in,
  input  logic            load_start,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic            cfg_bit,
  output logic            busy,
  output logic            out,
  output logic            out_valid
);

  localparam int              ROWS = 1 << N_IN;
  localparam int              CW   = $clog2(HOLD) + 1;
  localparam logic [N_IN-1:0] LAST = N_IN'(ROWS - 1);
  localparam logic [CW-1:0]   SAT  = CW'(HOLD - 1);

  typedef enum logic {
    IDLE,
    LOAD
  } state_e;

  state_e          state_q, state_d;
  logic [ROWS-1:0] tt_q, tt_d;
  logic [ROWS-1:0] shadow_q, shadow_d;
  logic [N_IN-1:0] count_q, count_d;
  logic [N_IN-1:0] in_q;
  logic [CW-1:0]   cnt_q;
  logic            out_q;
  logic            out_valid_q;
  logic            accept;
  logic            commit;

  // Load sequencing: shift table bits into the shadow, commit on the last row.
  always_comb begin
    state_d  = state_q;
    tt_d     = tt_q;
    shadow_d = shadow_q;
    count_d  = count_q;
    accept   = (state_q == LOAD) && cfg_valid;
    commit   = accept && (count_q == LAST);
    unique case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d  = LOAD;
          count_d  = '0;
          shadow_d = '0;
        end
      end
      LOAD: begin
        if (commit) begin
          shadow_d[count_q] = cfg_bit;
          tt_d              = shadow_d;
          state_d           = IDLE;
        end else if (load_start) begin
          count_d  = '0;
          shadow_d = '0;
        end else if (accept) begin
          shadow_d[count_q] = cfg_bit;
          count_d           = count_q + 1'b1;
        end
      end
    endcase
  end

  // Load state, active table, shadow table and bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      tt_q     <= RESET_TT;
      shadow_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      tt_q     <= tt_d;
      shadow_q <= shadow_d;
      count_q  <= count_d;
    end
  end

  // Settling filter: a change or a table commit restarts the stability count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q        <= '0;
      cnt_q       <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      in_q <= in;
      if (commit || (in != in_q)) begin
        cnt_q       <= '0;
        out_valid_q <= 1'b0;
      end else if (cnt_q < SAT) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        out_q       <= tt_q[in_q];
        out_valid_q <= 1'b1;
      end
    end
  end

  assign cfg_ready = (state_q == LOAD);
  assign busy      = (state_q == LOAD);
  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule
